rx_byte_packer: RTL and testbench

- Sits directly downstream of dot11. Consumes its decoded byte stream (byte_out / byte_out_strobe), the packet header strobe and the FCS result.
- Frames each packet as a sequence of 64-bit words: header word, zero or more payload words, status word.
- Buffers the words in an internal FIFO and presents them on a valid/ready output toward the DMA/AXI-stream side.

---
 rtl/rx_byte_packer.sv | 229 ++++++++++++++++++++++
 tb/tb_rx_byte_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_packer.sv
// Packs the decoded byte stream into 64-bit header/payload/status words behind a FWFT FIFO.
// Define RX_PKT_SN_EN to carry a packet sequence number in header bits [47:32].
module rx_byte_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               pkt_header_valid_strobe,
    input  logic [15:0]        pkt_len,
    input  logic [7:0]         byte_in,
    input  logic               byte_in_strobe,
    input  logic               fcs_out_strobe,
    input  logic               fcs_ok,
    output logic [63:0]        word_out,
    output logic               word_out_valid,
    input  logic               word_out_ready,
    output logic               word_out_last,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PACK,
        S_FLUSH,
        S_STATUS,
        S_ABORT,
        S_HEADER
    } state_t;

    localparam logic [FIFO_AW:0] DEPTH_C = FIFO_DEPTH[FIFO_AW:0];

    state_t      state;
    logic [2:0]  lane_idx;
    logic [63:0] asm_word;
    logic [15:0] byte_cnt;
    logic [15:0] cur_len;
    logic        hdr_pend;
    logic        fcs_ok_q;
    logic        push_req;
    logic [63:0] push_word;
    logic        push_last;

    logic hdr_stb;
    logic byte_stb;
    logic fcs_stb;

    assign hdr_stb  = enable & pkt_header_valid_strobe;
    assign byte_stb = enable & byte_in_strobe;
    assign fcs_stb  = enable & fcs_out_strobe;

    logic [15:0] sn_val;

`ifdef RX_PKT_SN_EN
    logic hdr_fire;

    assign hdr_fire = (state == S_IDLE && hdr_stb) || state == S_HEADER;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sn_val <= '0;
        end else if (hdr_fire) begin
            sn_val <= sn_val + 16'd1;
        end
    end
`else
    assign sn_val = '0;
`endif

    function automatic logic [63:0] hdr_word(input logic [15:0] len,
                                             input logic [15:0] sn);
        return {16'h0, sn, 16'h0, len};
    endfunction

    function automatic logic [63:0] stat_word(input logic ok,
                                              input logic abrt,
                                              input logic [15:0] cnt);
        return {ok, abrt, 46'h0, cnt};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lane_idx  <= '0;
            asm_word  <= '0;
            byte_cnt  <= '0;
            cur_len   <= '0;
            hdr_pend  <= 1'b0;
            fcs_ok_q  <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
            push_last <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            push_last <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hdr_stb) begin
                        cur_len   <= pkt_len;
                        push_req  <= 1'b1;
                        push_word <= hdr_word(pkt_len, sn_val);
                        byte_cnt  <= '0;
                        lane_idx  <= '0;
                        asm_word  <= '0;
                        state     <= S_PACK;
                    end
                end
                S_PACK: begin
                    if (hdr_stb) begin
                        // New header mid-packet: drop the partial word
                        cur_len  <= pkt_len;
                        asm_word <= '0;
                        lane_idx <= '0;
                        state    <= S_ABORT;
                    end else begin
                        if (byte_stb) begin
                            if (byte_cnt != 16'hFFFF) begin
                                byte_cnt <= byte_cnt + 16'd1;
                            end
                            if (lane_idx == 3'd7) begin
                                push_req  <= 1'b1;
                                push_word <= {byte_in, asm_word[55:0]};
                                asm_word  <= '0;
                                lane_idx  <= '0;
                            end else begin
                                asm_word[{lane_idx, 3'b000} +: 8] <= byte_in;
                                lane_idx <= lane_idx + 3'd1;
                            end
                        end
                        if (fcs_stb) begin
                            fcs_ok_q <= fcs_ok;
                            state    <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (hdr_stb) begin
                        hdr_pend <= 1'b1;
                        cur_len  <= pkt_len;
                    end
                    if (lane_idx != 3'd0) begin
                        push_req  <= 1'b1;
                        push_word <= asm_word;
                    end
                    asm_word <= '0;
                    lane_idx <= '0;
                    state    <= S_STATUS;
                end
                S_STATUS: begin
                    push_req  <= 1'b1;
                    push_last <= 1'b1;
                    push_word <= stat_word(fcs_ok_q, 1'b0, byte_cnt);
                    hdr_pend  <= 1'b0;
                    if (hdr_stb) begin
                        cur_len <= pkt_len;
                    end
                    state <= (hdr_stb || hdr_pend) ? S_HEADER : S_IDLE;
                end
                S_ABORT: begin
                    push_req  <= 1'b1;
                    push_last <= 1'b1;
                    push_word <= stat_word(1'b0, 1'b1, byte_cnt);
                    if (hdr_stb) begin
                        cur_len <= pkt_len;
                    end
                    state <= S_HEADER;
                end
                S_HEADER: begin
                    push_req  <= 1'b1;
                    push_word <= hdr_word(cur_len, sn_val);
                    byte_cnt  <= '0;
                    lane_idx  <= '0;
                    asm_word  <= '0;
                    state     <= S_PACK;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [64:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               pop;
    logic               wr_ok;

    assign full  = count == DEPTH_C;
    assign pop   = word_out_valid & word_out_ready;
    // A full FIFO still accepts a push when the same cycle pops
    assign wr_ok = push_req & (~full | pop);

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {push_last, push_word};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (push_req && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign word_out_valid = count != '0;
    assign {word_out_last, word_out} = word_out_valid ? mem[rd_ptr] : 65'h0;
    assign fifo_count = count;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Directed bench for rx_byte_packer: framing, abort, pending header, overflow, reset.
module tb_rx_byte_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        pkt_header_valid_strobe;
    logic [15:0] pkt_len;
    logic [7:0]  byte_in;
    logic        byte_in_strobe;
    logic        fcs_out_strobe;
    logic        fcs_ok;
    logic [63:0] word_out;
    logic        word_out_valid;
    logic        word_out_ready;
    logic        word_out_last;
    logic        overflow;
    logic [4:0]  fifo_count;

    int total = 0;
    int bad = 0;
    logic [15:0] sn_exp = 16'd0;
    logic [64:0] q [$];

    rx_byte_packer #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable                  (enable),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .pkt_len                 (pkt_len),
        .byte_in                 (byte_in),
        .byte_in_strobe          (byte_in_strobe),
        .fcs_out_strobe          (fcs_out_strobe),
        .fcs_ok                  (fcs_ok),
        .word_out                (word_out),
        .word_out_valid          (word_out_valid),
        .word_out_ready          (word_out_ready),
        .word_out_last           (word_out_last),
        .overflow                (overflow),
        .fifo_count              (fifo_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && word_out_valid && word_out_ready) begin
            q.push_back({word_out_last, word_out});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [64:0] obs,
                         input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send_header(input logic [15:0] len);
        pkt_header_valid_strobe = 1'b1;
        pkt_len = len;
        tick();
        pkt_header_valid_strobe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fcs,
                             input logic ok);
        byte_in = b;
        byte_in_strobe = 1'b1;
        fcs_out_strobe = fcs;
        fcs_ok = ok;
        tick();
        byte_in_strobe = 1'b0;
        fcs_out_strobe = 1'b0;
    endtask

    task automatic send_fcs(input logic ok);
        fcs_out_strobe = 1'b1;
        fcs_ok = ok;
        tick();
        fcs_out_strobe = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [63:0] w,
                               input logic l);
        int n = 0;
        logic [64:0] got;
        while (q.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: timeout, got none want %h", tag, {l, w});
        end else begin
            got = q.pop_front();
            check(tag, got, {l, w});
        end
    endtask

    task automatic expect_hdr(input string tag, input logic [15:0] len);
        logic [15:0] snf;
`ifdef RX_PKT_SN_EN
        snf = sn_exp;
`else
        snf = 16'h0;
`endif
        sn_exp = sn_exp + 16'd1;
        expect_word(tag, {16'h0, snf, 16'h0, len}, 1'b0);
    endtask

    initial begin
        logic [63:0] w;
        reset = 1'b1;
        enable = 1'b1;
        pkt_header_valid_strobe = 1'b0;
        pkt_len = '0;
        byte_in = '0;
        byte_in_strobe = 1'b0;
        fcs_out_strobe = 1'b0;
        fcs_ok = 1'b0;
        word_out_ready = 1'b1;
        tick();
        tick();
        check("rst_word", {1'b0, word_out}, 65'h0);
        check("rst_valid", {64'h0, word_out_valid}, 65'h0);
        check("rst_last", {64'h0, word_out_last}, 65'h0);
        check("rst_ovf", {64'h0, overflow}, 65'h0);
        check("rst_count", {60'h0, fifo_count}, 65'h0);
        reset = 1'b0;
        tick();

        // 10-byte packet, latency of the first payload word
        send_header(16'd10);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0);
        check("lat_pre", {64'h0, word_out_valid}, 65'h0);
        send_byte(8'd9, 1'b0, 1'b0);
        check("lat_valid", {64'h0, word_out_valid}, 65'h1);
        check("lat_word", {1'b0, word_out}, {1'b0, 64'h0807_0605_0403_0201});
        send_byte(8'd10, 1'b0, 1'b0);
        send_fcs(1'b1);
        expect_hdr("p1_hdr", 16'd10);
        expect_word("p1_w0", 64'h0807_0605_0403_0201, 1'b0);
        expect_word("p1_w1", 64'h0000_0000_0000_0A09, 1'b0);
        expect_word("p1_stat", 64'h8000_0000_0000_000A, 1'b1);

        // 8 bytes with FCS on the last byte, no padding word
        send_header(16'd8);
        for (int i = 0; i < 7; i++) send_byte(8'hFF, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        expect_hdr("p2_hdr", 16'd8);
        expect_word("p2_w0", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        expect_word("p2_stat", 64'h0000_0000_0000_0008, 1'b1);
        repeat (10) tick();
        check("p2_nopad", 65'(q.size()), 65'h0);

        // header strobe mid-packet aborts it
        send_header(16'd5);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        send_header(16'd2);
        tick();
        tick();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_fcs(1'b1);
        expect_hdr("p3_hdr", 16'd5);
        expect_word("p3_abort", 64'h4000_0000_0000_0003, 1'b1);
        expect_hdr("p4_hdr", 16'd2);
        expect_word("p4_w0", 64'h0000_0000_0000_2211, 1'b0);
        expect_word("p4_stat", 64'h8000_0000_0000_0002, 1'b1);

        // header strobe while flushing is held pending
        send_header(16'd3);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b1, 1'b1);
        send_header(16'd4);
        repeat (3) tick();
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h30, 1'b0, 1'b0);
        send_byte(8'h40, 1'b0, 1'b0);
        send_fcs(1'b0);
        expect_hdr("p5_hdr", 16'd3);
        expect_word("p5_w0", 64'h0000_0000_0003_0201, 1'b0);
        expect_word("p5_stat", 64'h8000_0000_0000_0003, 1'b1);
        expect_hdr("p6_hdr", 16'd4);
        expect_word("p6_w0", 64'h0000_0000_4030_2010, 1'b0);
        expect_word("p6_stat", 64'h0000_0000_0000_0004, 1'b1);

        // 20 words into a 16-deep FIFO with ready low
        word_out_ready = 1'b0;
        send_header(16'd144);
        for (int k = 0; k < 144; k++) send_byte(8'(k), 1'b0, 1'b0);
        send_fcs(1'b1);
        repeat (5) tick();
        check("ovf_count", {60'h0, fifo_count}, 65'd16);
        check("ovf_flag", {64'h0, overflow}, 65'h1);
        word_out_ready = 1'b1;
        expect_hdr("ovf_hdr", 16'd144);
        for (int j = 0; j < 15; j++) begin
            w = '0;
            for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(8 * j + b);
            expect_word($sformatf("ovf_w%0d", j), w, 1'b0);
        end
        repeat (10) tick();
        check("ovf_exact", 65'(q.size()), 65'h0);
        check("ovf_sticky", {64'h0, overflow}, 65'h1);

        // reset mid-packet with 5 words buffered
        word_out_ready = 1'b0;
        send_header(16'd100);
        for (int k = 0; k < 32; k++) send_byte(8'(k), 1'b0, 1'b0);
        repeat (3) tick();
        check("pre_rst_count", {60'h0, fifo_count}, 65'd5);
        #2 reset = 1'b1;
        #1;
        check("arst_word", {1'b0, word_out}, 65'h0);
        check("arst_valid", {64'h0, word_out_valid}, 65'h0);
        check("arst_last", {64'h0, word_out_last}, 65'h0);
        check("arst_ovf", {64'h0, overflow}, 65'h0);
        check("arst_count", {60'h0, fifo_count}, 65'h0);
        tick();
        reset = 1'b0;
        word_out_ready = 1'b1;
        q.delete();
        sn_exp = 16'd0;
        tick();
        send_header(16'd3);
        send_byte(8'h07, 1'b0, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h09, 1'b0, 1'b0);
        send_fcs(1'b1);
        expect_hdr("post_hdr", 16'd3);
        expect_word("post_w0", 64'h0000_0000_0009_0807, 1'b0);
        expect_word("post_stat", 64'h8000_0000_0000_0003, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
